// File: rtl/me_vector_buffer.sv
// rtl/me_vector_buffer.sv - motion-estimation result capture, FIFO queue and per-frame best tracking
//
// Purpose:
//   Watches the engine trigger/done handshake and captures one
//   {distance, vectorX, vectorY} result per search. Each result is tagged
//   with a per-frame block index and queued in a first-word-fall-through
//   FIFO that a consumer drains over a valid/ready port. The block also
//   tracks the minimum-distance block of the current frame.
//
// Optional feature macro: ME_VECTOR_STATS_EN
//   When defined, adds sumDistance (saturating per-frame distance sum) and
//   capCount (saturating per-frame capture count).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   frameStart              one-cycle pulse opening a new frame
//   trigger, done           engine start strobe / completion level
//   distance                engine SAD result
//   vectorX, vectorY        engine motion vector (two's complement)
//   outReady                consumer accepts the head entry
//   outValid                FIFO not empty
//   outIndex, outDistance   head entry index and distance
//   outVectorX, outVectorY  head entry vector
//   level                   number of queued entries
//   overflow                sticky: a result was dropped this frame
//   bestDistance, bestIndex minimum distance this frame and its block index
//   sumDistance, capCount   (ME_VECTOR_STATS_EN only) per-frame statistics

module me_vector_buffer #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frameStart,
   input  logic          trigger,
   input  logic          done,
   input  logic [7:0]    distance,
   input  logic [3:0]    vectorX,
   input  logic [3:0]    vectorY,
   input  logic          outReady,
   output logic          outValid,
   output logic [7:0]    outIndex,
   output logic [7:0]    outDistance,
   output logic [3:0]    outVectorX,
   output logic [3:0]    outVectorY,
   output logic [AW:0]   level,
   output logic          overflow,
   output logic [7:0]    bestDistance,
   output logic [7:0]    bestIndex
`ifdef ME_VECTOR_STATS_EN
   ,
   output logic [15:0]   sumDistance,
   output logic [7:0]    capCount
`endif
);

   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   // Entry layout: {index[23:16], distance[15:8], vectorX[7:4], vectorY[3:0]}
   logic [23:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic          r_armed;
   logic [7:0]    r_blk_idx;
   logic          r_overflow;
   logic [7:0]    r_best_dist;
   logic [7:0]    r_best_idx;

   logic          w_capture;
   logic          w_pop;
   logic          w_full;
   logic          w_push;
   logic          w_drop;
   logic [7:0]    w_cap_idx;
   logic [7:0]    w_best_base;
   logic          w_new_best;
   logic [23:0]   w_head;

   // A capture needs a prior trigger; trigger in the same cycle wins so a
   // back-to-back restart is never mistaken for completion of the old search.
   assign w_capture = r_armed && done && !trigger;
   assign w_pop     = (r_count != '0) && outReady;
   assign w_full    = (r_count == FULL_COUNT);
   // A full FIFO still accepts when the head leaves on the same edge: the
   // written slot is the one being vacated.
   assign w_push    = w_capture && (!w_full || w_pop);
   assign w_drop    = w_capture && w_full && !w_pop;

   // frameStart restarts numbering and the best search in the same cycle,
   // so a coincident capture is treated as the first block of the new frame.
   assign w_cap_idx   = frameStart ? 8'd0  : r_blk_idx;
   assign w_best_base = frameStart ? 8'hFF : r_best_dist;
   assign w_new_best  = w_capture && (distance < w_best_base);

   // ---------------------------------------------------------------------
   // Arm flag and block index
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed <= 1'b0;
      end else if (trigger) begin
         r_armed <= 1'b1;
      end else if (w_capture) begin
         r_armed <= 1'b0;
      end
   end

   // Index advances on every capture, dropped or not, so gaps are visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blk_idx <= 8'd0;
      end else if (w_capture) begin
         r_blk_idx <= w_cap_idx + 8'd1;
      end else if (frameStart) begin
         r_blk_idx <= 8'd0;
      end
   end

   // ---------------------------------------------------------------------
   // FIFO storage and pointers
   // ---------------------------------------------------------------------
   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {w_cap_idx, distance, vectorX, vectorY};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Overflow and best tracking
   // ---------------------------------------------------------------------
   // A drop in the frameStart cycle belongs to the new frame, so set wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (frameStart) begin
         r_overflow <= 1'b0;
      end
   end

   // Strict less-than keeps the earlier block on ties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_best_dist <= 8'hFF;
         r_best_idx  <= 8'd0;
      end else if (w_new_best) begin
         r_best_dist <= distance;
         r_best_idx  <= w_cap_idx;
      end else if (frameStart) begin
         r_best_dist <= 8'hFF;
         r_best_idx  <= 8'd0;
      end
   end

   // ---------------------------------------------------------------------
   // Optional per-frame statistics
   // ---------------------------------------------------------------------
`ifdef ME_VECTOR_STATS_EN
   logic [15:0] r_sum;
   logic [7:0]  r_cap_cnt;
   logic [15:0] w_sum_base;
   logic [7:0]  w_cnt_base;
   logic [16:0] w_sum_ext;

   assign w_sum_base = frameStart ? 16'd0 : r_sum;
   assign w_cnt_base = frameStart ? 8'd0  : r_cap_cnt;
   assign w_sum_ext  = {1'b0, w_sum_base} + {9'd0, distance};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum     <= 16'd0;
         r_cap_cnt <= 8'd0;
      end else if (w_capture) begin
         r_sum     <= w_sum_ext[16] ? 16'hFFFF : w_sum_ext[15:0];
         r_cap_cnt <= (w_cnt_base == 8'hFF) ? 8'hFF : w_cnt_base + 8'd1;
      end else if (frameStart) begin
         r_sum     <= 16'd0;
         r_cap_cnt <= 8'd0;
      end
   end

   assign sumDistance = r_sum;
   assign capCount    = r_cap_cnt;
`endif

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign outValid = (r_count != '0);
   assign w_head   = outValid ? r_mem[r_rd_ptr] : 24'd0;

   assign outIndex     = w_head[23:16];
   assign outDistance  = w_head[15:8];
   assign outVectorX   = w_head[7:4];
   assign outVectorY   = w_head[3:0];
   assign level        = r_count;
   assign overflow     = r_overflow;
   assign bestDistance = r_best_dist;
   assign bestIndex    = r_best_idx;

endmodule

// File: doc/me_vector_buffer.md
# me_vector_buffer

Downstream result stage for the motion-estimation engine. Watches the engine's `trigger`/`done` handshake, captures one `{distance, vectorX, vectorY}` result per search, tags it with a per-frame block index, and queues it in a small FIFO. A consumer drains the queue over a valid/ready port. The block also tracks the best (minimum-distance) block of the current frame.

## Interface
- `DEPTH`, 8: FIFO entries; a power of two, 2..64.
- `AW`, $clog2(DEPTH): pointer width, derived; do not override.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `frameStart`  in  1  one-cycle pulse that starts a new frame.
- `trigger`  in  1  engine start strobe, observed only.
- `done`  in  1  engine completion, level.
- `distance`  in  8  engine SAD result, unsigned.
- `vectorX`, `vectorY`  in  4 each  engine motion vector, two's complement, range -8..7.
- `outReady`  in  1  consumer accepts the head entry.
- `outValid`  out  1  FIFO is not empty.
- `outIndex`  out  8  block index of the head entry.
- `outDistance`  out  8  distance of the head entry.
- `outVectorX`, `outVectorY`  out  4 each  vector of the head entry, passed through bit-exact.
- `level`  out  AW+1  current number of entries.
- `overflow`  out  1  sticky: at least one result was dropped.
- `bestDistance`  out  8  minimum distance seen this frame.
- `bestIndex`  out  8  block index of `bestDistance`.

## Operation
- Arm and capture:
  - `armed` sets on any cycle with `trigger`=1.
  - Capture happens on a cycle with `armed && done && !trigger`. That cycle clears `armed`.
  - Exactly one capture per trigger. `done` held high afterwards does not capture again.
  - `done` already high at reset release, with no prior trigger, is ignored.
- Block index:
  - `blkIdx` is 8 bits. It increments on every capture, including dropped ones, so the consumer can see gaps.
  - It wraps from 255 to 0.
  - The entry is written with the pre-increment value.
- FIFO:
  - Circular buffer with read and write pointers of AW bits and a count of AW+1 bits.
  - Output is first-word-fall-through: the head entry is always presented on the `out*` ports.
  - Pop occurs when `outValid && outReady`.
- Full FIFO: a capture without a pop in the same cycle is dropped and sets `overflow`. A capture with a same-cycle pop is accepted.
- Empty FIFO: there is no bypass. `outReady` with an empty FIFO has no effect.
- Best tracking:
  - On each capture, dropped or not, if `distance < bestDistance`, update `bestDistance` and `bestIndex`.
  - Ties keep the earlier entry.
- `frameStart`:
  - Sets `blkIdx`=0, `bestDistance`=8'hFF, `bestIndex`=0, and clears `overflow`.
  - Does not flush the FIFO and does not touch `armed`.
  - If a capture happens in the same cycle, the capture uses index 0 and is compared against 8'hFF. After that cycle `blkIdx`=1.
- Reset values:
  - All-zero FIFO pointers and count, `armed`=0, `blkIdx`=0.
  - `outValid`=0, `level`=0, `overflow`=0, `bestDistance`=8'hFF, `bestIndex`=0.
  - `out*` data ports read 0.

## Timing
- Capture at edge N: `outValid` rises after edge N (visible in cycle N+1) when the FIFO was empty. `level` updates at the same edge.
- Pop at edge N: the next entry is presented in cycle N+1.
- Simultaneous push and pop: `level` is unchanged.
- Best values update at the capture edge.
- Reset asserted mid-frame: all state clears immediately, without a clock edge. Entries pending in the FIFO are lost.

## Configuration
- `ME_VECTOR_STATS_EN` defined adds two outputs:
  - `sumDistance` (16 bits): saturating sum of captured distances this frame.
  - `capCount` (8 bits): number of captures this frame, saturating at 255.
  - Both clear on reset and on `frameStart`.
  - On a same-cycle `frameStart` and capture, both take the captured values: `sumDistance`=`distance`, `capCount`=1.
- `ME_VECTOR_STATS_EN` not defined: neither port exists and no accumulator logic is built.

## Test plan
- Single search: trigger 1 cycle, `done` high 3 cycles later with distance=0x2A, X=4'hF, Y=4'h3 -> one entry {idx 0, 0x2A, F, 3}; `outValid` one cycle after capture; `done` held 10 cycles gives no second entry.
- Fill past full (DEPTH=8) with 9 searches and `outReady`=0 -> `level`=8, `overflow`=1; drain shows indices 0..7; next capture gets index 9.
- Full FIFO with capture and pop in the same cycle -> `level` stays 8, no overflow, new entry at tail.
- Distances 0x50, 0x20, 0x20, 0x90 -> `bestDistance`=0x20, `bestIndex`=1; after `frameStart`, `bestDistance`=0xFF and `bestIndex`=0.
- 256 captures -> index wraps 255 to 0. Then assert `rst_n` low mid-drain -> `outValid`=0 and `level`=0 immediately.
- With `ME_VECTOR_STATS_EN`: 300 captures of 0xFF -> `sumDistance`=16'hFFFF, `capCount`=255.
